// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader: packs a narrow valid/ready word stream into full LUT images
// and writes NUM_LUTS consecutive images to the LUT bank update port, each
// tagged with an incrementing table index.
module lut_cfg_loader #(
    parameter int IN_WIDTH  = 16,
    parameter int LUT_DEPTH = 16,
    parameter int LUT_WIDTH = 4,
    parameter int NUM_LUTS  = 16,
    localparam int IMG_W    = LUT_DEPTH * LUT_WIDTH,
    localparam int WPT      = IMG_W / IN_WIDTH,
    localparam int ID_W     = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [IN_WIDTH-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                cfg_update,
    output logic                lut_wr_valid,
    output logic [IMG_W-1:0]    lut_wr_data,
    output logic [ID_W-1:0]     lut_wr_id,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    localparam int WC_W = (WPT > 1) ? $clog2(WPT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ISSUE   = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [WC_W-1:0]   wcnt_r, wcnt_s;
    logic [IMG_W-1:0]  img_r, img_s;
    logic              wr_valid_s;
    logic [IMG_W-1:0]  wr_data_s;
    logic [ID_W-1:0]   wr_id_s;
    logic              busy_s;
    logic              cfg_s;
    logic              done_s;
    logic              aborted_s;

    // Ready is the only combinational output: words are taken only while collecting.
    assign s_ready = (state_r == COLLECT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-output decode; abort takes priority over any other action.
    always_comb begin
        state_s    = state_r;
        wcnt_s     = wcnt_r;
        img_s      = img_r;
        wr_valid_s = 1'b0;
        wr_data_s  = lut_wr_data;
        wr_id_s    = lut_wr_id;
        busy_s     = busy;
        cfg_s      = cfg_update;
        done_s     = 1'b0;
        aborted_s  = aborted;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_s   = COLLECT;
                    wcnt_s    = {WC_W{1'b0}};
                    wr_id_s   = {ID_W{1'b0}};
                    aborted_s = 1'b0;
                    busy_s    = 1'b1;
                    cfg_s     = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_s   = IDLE;
                    wcnt_s    = {WC_W{1'b0}};
                    img_s     = {IMG_W{1'b0}};
                    aborted_s = 1'b1;
                    busy_s    = 1'b0;
                    cfg_s     = 1'b0;
                end else if (s_valid) begin
                    img_s[wcnt_r*IN_WIDTH +: IN_WIDTH] = s_data;
                    if (wcnt_r == WC_W'(WPT - 1)) begin
                        // Last word: launch the write strobe on this same edge.
                        state_s    = ISSUE;
                        wcnt_s     = {WC_W{1'b0}};
                        wr_valid_s = 1'b1;
                        wr_data_s  = img_s;
                    end else begin
                        wcnt_s = wcnt_r + WC_W'(1);
                    end
                end else begin
                    state_s = COLLECT;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_s   = IDLE;
                    wcnt_s    = {WC_W{1'b0}};
                    aborted_s = 1'b1;
                    busy_s    = 1'b0;
                    cfg_s     = 1'b0;
                end else if (lut_wr_id == ID_W'(NUM_LUTS - 1)) begin
                    state_s = IDLE;
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    cfg_s   = 1'b0;
                end else begin
                    state_s = COLLECT;
                    wr_id_s = lut_wr_id + ID_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                cfg_s   = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs; write data and id hold their values while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt_r       <= {WC_W{1'b0}};
            img_r        <= {IMG_W{1'b0}};
            lut_wr_valid <= 1'b0;
            lut_wr_data  <= {IMG_W{1'b0}};
            lut_wr_id    <= {ID_W{1'b0}};
            busy         <= 1'b0;
            cfg_update   <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            wcnt_r       <= wcnt_s;
            img_r        <= img_s;
            lut_wr_valid <= wr_valid_s;
            lut_wr_data  <= wr_data_s;
            lut_wr_id    <= wr_id_s;
            busy         <= busy_s;
            cfg_update   <= cfg_s;
            done         <= done_s;
            aborted      <= aborted_s;
        end
    end

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Scoreboard bench for lut_cfg_loader: expected images are queued when a
// session is launched and a negedge monitor pops/compares each write strobe.
module tb_lut_cfg_loader;

    localparam int IN_W   = 16;
    localparam int IMG_W  = 64;
    localparam int WPT    = 4;
    localparam int NLUT   = 16;
    localparam int ID_W   = 4;
    localparam int NWORDS = NLUT * WPT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [IN_W-1:0]   s_data = 16'h0000;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              cfg_update;
    logic              lut_wr_valid;
    logic [IMG_W-1:0]  lut_wr_data;
    logic [ID_W-1:0]   lut_wr_id;
    logic              busy;
    logic              done;
    logic              aborted;

    // Variant instance: 32-bit words, a single table per session
    logic              v_start = 1'b0;
    logic              v_abort = 1'b0;
    logic [31:0]       v_s_data = 32'h0;
    logic              v_s_valid = 1'b0;
    logic              v_s_ready;
    logic              v_cfg_update;
    logic              v_lut_wr_valid;
    logic [63:0]       v_lut_wr_data;
    logic [0:0]        v_lut_wr_id;
    logic              v_busy;
    logic              v_done;
    logic              v_aborted;

    lut_cfg_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .cfg_update(cfg_update), .lut_wr_valid(lut_wr_valid),
        .lut_wr_data(lut_wr_data), .lut_wr_id(lut_wr_id),
        .busy(busy), .done(done), .aborted(aborted)
    );

    lut_cfg_loader #(.IN_WIDTH(32), .NUM_LUTS(1)) dut_v (
        .clk(clk), .rst(rst), .start(v_start), .abort(v_abort),
        .s_data(v_s_data), .s_valid(v_s_valid), .s_ready(v_s_ready),
        .cfg_update(v_cfg_update), .lut_wr_valid(v_lut_wr_valid),
        .lut_wr_data(v_lut_wr_data), .lut_wr_id(v_lut_wr_id),
        .busy(v_busy), .done(v_done), .aborted(v_aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [IMG_W-1:0] data;
    } exp_t;

    exp_t            exp_q[$];
    exp_t            mon_e;
    logic [IN_W-1:0] words [NWORDS];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_accept_edge = 0;
    int done_cnt = 0;
    int done_seen = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge counter so timing checks can be expressed in clock edges.
    always @(posedge clk) cyc++;

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (lut_wr_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got id %0h data %0h, want no write", lut_wr_id, lut_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_data", lut_wr_data, mon_e.data);
                    chk("wr_id", lut_wr_id, mon_e.id);
                    chk("wr_latency", cyc, last_accept_edge);
                    chk("wr_s_ready_low", s_ready, 1'b0);
                    chk("wr_cfg_update", cfg_update, 1'b1);
                end
            end
            if (done) begin
                done_cnt++;
                done_seen = cyc + 1;
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_s_ready"}, s_ready, 1'b0);
        chk({tag, "_cfg_update"}, cfg_update, 1'b0);
        chk({tag, "_wr_valid"}, lut_wr_valid, 1'b0);
        chk({tag, "_wr_data"}, lut_wr_data, 64'h0);
        chk({tag, "_wr_id"}, lut_wr_id, 4'h0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_aborted"}, aborted, 1'b0);
    endtask

    // One session: queue the model's expected images, then stream the words.
    // abort_at >= 0 aborts when that many words have been accepted.
    task automatic run_session(input int gap_pct, input int abort_at, input int poke_at);
        int idx;
        int guard;
        int ntab;
        int start_edge;
        exp_t e;
        ntab = (abort_at >= 0) ? abort_at / WPT : NLUT;
        for (int t = 0; t < ntab; t++) begin
            e.id = ID_W'(t);
            e.data = {words[4*t+3], words[4*t+2], words[4*t+1], words[4*t]};
            exp_q.push_back(e);
        end
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_cfg_update", cfg_update, 1'b1);
        chk("start_aborted_cleared", aborted, 1'b0);
        idx = 0;
        guard = 0;
        while (idx < NWORDS && guard < 3000) begin
            if (abort_at >= 0 && idx == abort_at) begin
                abort = 1'b1;
                s_valid = 1'b1;
                s_data = words[idx];
                @(negedge clk);
                abort = 1'b0;
                s_valid = 1'b0;
                break;
            end
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data = s_valid ? words[idx] : 16'($urandom);
            start = (idx == poke_at);
            if (s_valid && s_ready) begin
                idx++;
                last_accept_edge = cyc + 1;
            end
            @(negedge clk);
            guard++;
        end
        s_valid = 1'b0;
        start = 1'b0;
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("FAIL session_timeout: got %0d words, want %0d", idx, NWORDS);
        end
        if (abort_at >= 0) begin
            repeat (3) @(negedge clk);
            chk("abort_aborted", aborted, 1'b1);
            chk("abort_busy", busy, 1'b0);
            chk("abort_cfg_update", cfg_update, 1'b0);
            chk("abort_s_ready", s_ready, 1'b0);
            chk("abort_no_done", done_cnt, 0);
        end else begin
            guard = 0;
            while (done_cnt == 0 && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            repeat (3) @(negedge clk);
            chk("done_count", done_cnt, 1);
            chk("done_after_last_issue", done_seen, last_accept_edge + 2);
            if (gap_pct == 0) chk("done_latency_from_start", done_seen - start_edge, 81);
            chk("end_busy", busy, 1'b0);
            chk("end_cfg_update", cfg_update, 1'b0);
            chk("end_aborted", aborted, 1'b0);
            chk("end_hold_id", lut_wr_id, 4'hF);
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("post_reset");

        // Full session, back-to-back words 0x0000..0x003F
        for (int i = 0; i < NWORDS; i++) words[i] = 16'(i);
        run_session(0, -1, -1);

        // Random gaps, fixed first image, start poked mid-session
        for (int i = 0; i < NWORDS; i++) words[i] = 16'($urandom);
        words[0] = 16'h3210; words[1] = 16'h7654; words[2] = 16'hBA98; words[3] = 16'hFEDC;
        run_session(40, -1, 10);

        // Abort after 2 words of table 5, then a clean restart
        for (int i = 0; i < NWORDS; i++) words[i] = 16'($urandom);
        run_session(20, 22, -1);
        for (int i = 0; i < NWORDS; i++) words[i] = 16'($urandom);
        run_session(20, -1, -1);

        // start together with abort in IDLE: stay idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 1'b0);
        chk("start_abort_s_ready", s_ready, 1'b0);
        chk("start_abort_cfg_update", cfg_update, 1'b0);

        // Reset in the middle of COLLECT
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 16'hDEAD;
        @(negedge clk);
        s_data = 16'hBEEF;
        @(negedge clk);
        s_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NWORDS; i++) words[i] = 16'($urandom);
        run_session(10, -1, -1);

        // Variant: 32-bit words, one table
        @(negedge clk);
        v_start = 1'b1;
        @(negedge clk);
        v_start = 1'b0;
        chk("v_s_ready", v_s_ready, 1'b1);
        v_s_valid = 1'b1;
        v_s_data = 32'h1234_5678;
        @(negedge clk);
        v_s_data = 32'h9ABC_DEF0;
        @(negedge clk);
        v_s_valid = 1'b0;
        chk("v_wr_valid", v_lut_wr_valid, 1'b1);
        chk("v_wr_data", v_lut_wr_data, 64'h9ABC_DEF0_1234_5678);
        chk("v_wr_id", v_lut_wr_id, 1'b0);
        chk("v_s_ready_issue", v_s_ready, 1'b0);
        @(negedge clk);
        chk("v_done", v_done, 1'b1);
        chk("v_busy", v_busy, 1'b0);
        chk("v_wr_valid_off", v_lut_wr_valid, 1'b0);
        @(negedge clk);
        chk("v_done_pulse", v_done, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
